// File: rtl/imem_loader_if.sv
// Byte-stream in, instruction-memory write port out.
// Loader side is the slave modport; the byte source drives the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata,
    output core_hold, done, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata,
    input  core_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream
// into instruction memory, holding the core while loading.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, DONE
  } st_t;

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  st_t st, st_n;

  logic              live;
  logic              hold_q;
  logic              err_q;
  logic [1:0]        bidx;
  logic [31:0]       n;
  logic [31:0]       wreg;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       len_full;
  logic              acc;
  logic              last_b;
  logic              too_big;

  assign acc = bus.in_valid && bus.in_ready;
  assign last_b = (bidx == 2'd3);
  assign len_full = {bus.in_data, n[31:8]};
  assign too_big = {1'b0, len_full} > CAP;
  assign cnt_inc = cnt + 1'b1;

  assign bus.in_ready = live &&
    (st == IDLE || st == LEN || st == DATA);
  assign bus.we = (st == WRITE);
  assign bus.done = (st == DONE);
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.core_hold = hold_q;
  assign bus.err = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  // Next-state: header, data bytes, one write cycle per word.
  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: if (acc) st_n = LEN;
      LEN: begin
        if (acc && last_b) begin
          if (len_full == 32'd0) st_n = DONE;
          else if (too_big)      st_n = IDLE;
          else                   st_n = DATA;
        end
      end
      DATA: if (acc && last_b) st_n = WRITE;
      WRITE: begin
        if (32'(cnt_inc) == n) st_n = DONE;
        else                   st_n = DATA;
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // Datapath: byte shift-in, counters, write-port and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live    <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      bidx    <= 2'd0;
      n       <= 32'd0;
      wreg    <= 32'd0;
      cnt     <= '0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
    end else begin
      live   <= 1'b1;
      hold_q <= (st_n == LEN) || (st_n == DATA) ||
                (st_n == WRITE);
      unique case (st)
        IDLE: begin
          if (acc) begin
            n     <= {bus.in_data, n[31:8]};
            bidx  <= 2'd1;
            err_q <= 1'b0;
          end
        end
        LEN: begin
          if (acc) begin
            n    <= len_full;
            bidx <= bidx + 2'd1;
            if (last_b) begin
              cnt <= '0;
              if (too_big) err_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (acc) begin
            wreg <= {bus.in_data, wreg[31:8]};
            bidx <= bidx + 2'd1;
            if (last_b) begin
              wdata_q <= {bus.in_data, wreg[31:8]};
              waddr_q <= cnt[ADDR_W-1:0];
            end
          end
        end
        WRITE: begin
          cnt  <= cnt_inc;
          bidx <= 2'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=4):
// normal load, empty load, oversize header, full load, mid-load reset.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n;

  imem_loader_if #(.ADDR_W(4)) bus ();

  imem_loader #(.ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int viol = 0;
  int dn = 0;
  bit armed = 1'b0;
  logic [3:0]  qa[$];
  logic [31:0] qd[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record writes/done; in_ready low exactly in WRITE/DONE,
  // core_hold high in WRITE and low in DONE.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.we) begin
        qa.push_back(bus.waddr);
        qd.push_back(bus.wdata);
        if (!bus.core_hold) viol++;
      end
      if (bus.done) begin
        dn++;
        if (bus.core_hold) viol++;
      end
      if ((bus.we || bus.done) && bus.in_ready) viol++;
      if (armed && !(bus.we || bus.done) && !bus.in_ready)
        viol++;
      if (bus.we && bus.done) viol++;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  // with in_valid still high.
  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    bit got;
    got = 1'b0;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    for (int k = 0; k < 50; k++) begin
      ok = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (ok) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++)
      send(w[8*k +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_done(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (dn >= target) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("done_wait", 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    armed = 1'b0;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    armed = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",    32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_hold",  32'(bus.core_hold), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("rel_ready0", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready1", 32'(bus.in_ready), 32'd1);
    armed = 1'b1;

    // Two-word load, in_valid held high throughout.
    send(8'h02, 0);
    chk("t1_hold", 32'(bus.core_hold), 32'd1);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t1_hold_len", 32'(bus.core_hold), 32'd1);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    bus.in_valid = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("t1_nwr", 32'(qa.size()), 32'd2);
    if (qa.size() == 2) begin
      chk("t1_a0", 32'(qa[0]), 32'd0);
      chk("t1_d0", qd[0], 32'h0000_0013);
      chk("t1_a1", 32'(qa[1]), 32'd1);
      chk("t1_d1", qd[1], 32'h0010_0093);
    end
    chk("t1_ndone", 32'(dn), 32'd1);
    chk("t1_hold_end", 32'(bus.core_hold), 32'd0);
    chk("t1_err", 32'(bus.err), 32'd0);
    chk("t1_waddr_hold", 32'(bus.waddr), 32'd1);
    chk("t1_wdata_hold", bus.wdata, 32'h0010_0093);
    qa.delete(); qd.delete();

    // Empty load.
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    bus.in_valid = 1'b0;
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_hold", 32'(bus.core_hold), 32'd0);
    repeat (3) @(negedge clk);
    chk("t2_nwr", 32'(qa.size()), 32'd0);
    chk("t2_ndone", 32'(dn), 32'd2);
    chk("t2_err", 32'(bus.err), 32'd0);

    // Oversize header: N=17 with 16-word capacity.
    send(8'h11, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    bus.in_valid = 1'b0;
    chk("t3_err", 32'(bus.err), 32'd1);
    chk("t3_hold", 32'(bus.core_hold), 32'd0);
    chk("t3_ready", 32'(bus.in_ready), 32'd1);
    chk("t3_done", 32'(bus.done), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_err_sticky", 32'(bus.err), 32'd1);
    chk("t3_nwr", 32'(qa.size()), 32'd0);
    chk("t3_ndone", 32'(dn), 32'd2);

    // Full-capacity load N=16 with random gaps.
    send(8'h10, 2);
    chk("t4_err_clr", 32'(bus.err), 32'd0);
    send(8'h00, 1); send(8'h00, 3); send(8'h00, 0);
    for (int i = 0; i < 16; i++)
      send_word(32'hA5C3_0000 + 32'(i) * 32'h0101_0011, 3);
    bus.in_valid = 1'b0;
    wait_done(3);
    repeat (2) @(negedge clk);
    chk("t4_nwr", 32'(qa.size()), 32'd16);
    if (qa.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("t4_a%0d", i), 32'(qa[i]), 32'(i));
        chk($sformatf("t4_d%0d", i), qd[i],
            32'hA5C3_0000 + 32'(i) * 32'h0101_0011);
      end
    end
    chk("t4_ndone", 32'(dn), 32'd3);
    chk("t4_err", 32'(bus.err), 32'd0);
    qa.delete(); qd.delete();

    // Reset after 2 bytes of word 1.
    send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send_word(32'hDEAD_BEEF, 0);
    send(8'h11, 0); send(8'h22, 0);
    armed = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_hold_pre", 32'(bus.core_hold), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_hold", 32'(bus.core_hold), 32'd0);
    chk("t5_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_waddr", 32'(bus.waddr), 32'd0);
    chk("t5_wdata", bus.wdata, 32'd0);
    chk("t5_we", 32'(bus.we), 32'd0);
    chk("t5_nwr", 32'(qa.size()), 32'd1);
    qa.delete(); qd.delete();
    dn = 0;
    @(negedge clk);
    do_reset();
    chk("t5_nwr_rst", 32'(qa.size()), 32'd0);
    send(8'h02, 0); send(8'h00, 1); send(8'h00, 0); send(8'h00, 2);
    send_word(32'h1234_5678, 2);
    send_word(32'h0BAD_F00D, 2);
    bus.in_valid = 1'b0;
    wait_done(1);
    repeat (2) @(negedge clk);
    chk("t6_nwr", 32'(qa.size()), 32'd2);
    if (qa.size() == 2) begin
      chk("t6_a0", 32'(qa[0]), 32'd0);
      chk("t6_d0", qd[0], 32'h1234_5678);
      chk("t6_a1", 32'(qa[1]), 32'd1);
      chk("t6_d1", qd[1], 32'h0BAD_F00D);
    end
    chk("t6_ndone", 32'(dn), 32'd1);

    chk("handshake_viol", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory word-address width; capacity is 2**ADDR_W words.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  byte-stream source has a valid byte.
REQ-005 in_data  input  8  byte value.
REQ-006 in_ready  output  1  loader accepts in_data this cycle.
REQ-007 we  output  1  instruction-memory write-port enable, one-cycle pulse per word.
REQ-008 waddr  output  ADDR_W  instruction-memory word address.
REQ-009 wdata  output  32  instruction word.
REQ-010 core_hold  output  1  holds the fetch stage and core in stall while a load is in progress.
REQ-011 done  output  1  one-cycle pulse when a load completes successfully.
REQ-012 err  output  1  sticky flag: the length header exceeded capacity.

Function
REQ-013 A byte is accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-014 Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte goes to wdata[7:0]).
REQ-015 States are IDLE, LEN, DATA, WRITE, DONE.
REQ-016 in_ready=1 in IDLE, LEN and DATA; in_ready=0 in WRITE and DONE.
REQ-017 IDLE: accepting a byte stores it as count byte 0, sets core_hold=1, clears err, and goes to LEN with byte index 1.
REQ-018 LEN: each accepted byte fills the next count byte; the 4th byte completes N.
REQ-019 After the 4th count byte: if N=0, go to DONE; if N>2**ADDR_W, set err=1, clear core_hold, and go to IDLE with no write; otherwise go to DATA with word counter 0 and byte index 0.
REQ-020 DATA: each accepted byte fills byte lane [byte index] of the word register; the 4th byte moves to WRITE.
REQ-021 WRITE lasts exactly one cycle, with we=1, waddr=word counter[ADDR_W-1:0] and wdata=the assembled word; latency is one cycle from acceptance of the 4th byte to the we pulse.
REQ-022 Leaving WRITE, the word counter increments; if the counter now equals N, go to DONE, else go to DATA with byte index 0.
REQ-023 DONE lasts one cycle: done=1 and core_hold=0 in that cycle, then go to IDLE.
REQ-024 core_hold=1 in LEN, DATA and WRITE, and in IDLE only while a cycle of byte acceptance is moving the block to LEN (the register is set on that edge).
REQ-025 Outside WRITE: we=0; waddr and wdata hold their last values.
REQ-026 Word counter width is ADDR_W+1, so that N=2**ADDR_W terminates without wrap; N=2**ADDR_W writes addresses 0..2**ADDR_W-1 exactly once.
REQ-027 Bytes arriving in WRITE or DONE are not consumed; the source holds them under the valid/ready rule.
REQ-028 A stalled stream (in_valid=0) waits indefinitely in any state; the block has no timeout.
REQ-029 err stays 1 until the next load begins (first header byte accepted) or until reset.

Reset
REQ-030 With rst_n=0: state IDLE, all counters 0, in_ready=0, we=0, waddr=0, wdata=0, core_hold=0, done=0, err=0; in_ready rises to 1 on the first clock edge after release.
REQ-031 Reset asserted mid-load aborts the load immediately: no further writes, core_hold drops asynchronously, and partial words are discarded.

Verification
REQ-032 Stream 02 00 00 00, 13 00 00 00, 93 00 10 00 with in_valid held high -> we pulses at (0,0x00000013) and (1,0x00100093); done pulses once; core_hold is 1 from the cycle after the first byte until the DONE cycle.
REQ-033 Header 00 00 00 00 -> no we pulse; done pulses in the cycle after the 4th byte; err=0.
REQ-034 ADDR_W=4, header 11 00 00 00 (N=17) -> err=1, no we pulse, no done pulse, core_hold=0, and the block returns to IDLE.
REQ-035 ADDR_W=4, N=16 with random in_valid gaps -> 16 writes to addresses 0..15 in order, then done; in_ready=0 exactly in the WRITE and DONE cycles.
REQ-036 rst_n pulled low after 2 data bytes of word 1 -> outputs return to reset values at once; the next full stream loads correctly from address 0.
